// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states and requester IDs.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      ARB,
      LOCKED,
      FORCE_CPU
   } arb_state_t;

   typedef enum logic {
      REQ_CPU,
      REQ_LD
   } req_id_t;

   // Round-robin tie winner: whoever was not granted most recently.
   function automatic req_id_t tie_winner(input req_id_t last_winner);
      return (last_winner == REQ_CPU) ? REQ_LD : REQ_CPU;
   endfunction

endpackage

// File: rtl/arb_burst_counter.sv
// Saturating count of locked loader grants; flags when the count being
// loaded at the next edge has reached MAX_BURST.
module arb_burst_counter #(
   parameter int MAX_BURST = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic start,
   input  logic inc,
   output logic at_limit
);

   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] LIMIT = CW'(MAX_BURST);

   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;

   always_comb begin
      count_nxt = count;
      if (clr)
         count_nxt = '0;
      else if (start)
         count_nxt = CW'(1);
      else if (inc && (count != LIMIT))
         count_nxt = count + 1'b1;
   end

   assign at_limit = (count_nxt >= LIMIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else
         count <= count_nxt;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data memory between the CPU load/store path and the loader port.
// Define DMEM_ARB_RR_EN for round-robin ties in ARB; otherwise the CPU wins ties.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32,
   parameter int MAX_BURST     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cpu_req,
   input  logic                     cpu_we,
   input  logic [ADDRESS_WIDTH-1:0] cpu_a,
   input  logic [DATA_WIDTH-1:0]    cpu_wd,
   output logic [DATA_WIDTH-1:0]    cpu_rd,
   output logic                     cpu_stall,
   input  logic                     ld_req,
   input  logic                     ld_we,
   input  logic                     ld_lock,
   input  logic [ADDRESS_WIDTH-1:0] ld_a,
   input  logic [DATA_WIDTH-1:0]    ld_wd,
   output logic                     ld_gnt,
   output logic                     ld_rvalid,
   output logic [DATA_WIDTH-1:0]    ld_rdata,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_a,
   output logic [DATA_WIDTH-1:0]    mem_wd,
   input  logic [DATA_WIDTH-1:0]    mem_rd
);

   arb_state_t state;
   logic       cpu_gnt;
   logic       cpu_wins_tie;
   logic       lock_hold;
   logic       burst_go;
   logic       at_limit;

`ifdef DMEM_ARB_RR_EN
   req_id_t last_winner;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_winner <= REQ_LD;
      else if (cpu_gnt)
         last_winner <= REQ_CPU;
      else if (ld_gnt)
         last_winner <= REQ_LD;
   end

   assign cpu_wins_tie = (tie_winner(last_winner) == REQ_CPU);
`else
   assign cpu_wins_tie = 1'b1;
`endif

   // A locked burst only persists while the loader keeps both req and lock up;
   // otherwise the cycle falls back to the ordinary ARB decision.
   assign lock_hold = (state == LOCKED) && ld_req && ld_lock;

   always_comb begin
      cpu_gnt = 1'b0;
      ld_gnt  = 1'b0;
      if (state == FORCE_CPU) begin
         cpu_gnt = cpu_req;
      end else if (lock_hold) begin
         ld_gnt = 1'b1;
      end else if (cpu_req && ld_req) begin
         cpu_gnt = cpu_wins_tie;
         ld_gnt  = ~cpu_wins_tie;
      end else begin
         cpu_gnt = cpu_req;
         ld_gnt  = ld_req;
      end
   end

   assign cpu_stall = cpu_req & ~cpu_gnt;
   assign cpu_rd    = cpu_gnt ? mem_rd : '0;

   always_comb begin
      mem_we = 1'b0;
      mem_a  = '0;
      mem_wd = '0;
      if (cpu_gnt) begin
         mem_we = cpu_we;
         mem_a  = cpu_a;
         mem_wd = cpu_wd;
      end else if (ld_gnt) begin
         mem_we = ld_we;
         mem_a  = ld_a;
         mem_wd = ld_wd;
      end
   end

   assign burst_go = ld_gnt & ld_lock;

   arb_burst_counter #(
      .MAX_BURST (MAX_BURST)
   ) u_burst_counter (
      .clk      (clk),
      .rst      (rst),
      .clr      (~burst_go),
      .start    (burst_go & ~lock_hold),
      .inc      (lock_hold & cpu_req),
      .at_limit (at_limit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ARB;
         ld_rvalid <= 1'b0;
         ld_rdata  <= '0;
      end else begin
         ld_rvalid <= ld_gnt & ~ld_we;
         if (ld_gnt && !ld_we)
            ld_rdata <= mem_rd;

         if (state == FORCE_CPU)
            state <= ARB;
         else if (burst_go)
            state <= (cpu_req && at_limit) ? FORCE_CPU : LOCKED;
         else
            state <= ARB;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed table, corner-case sequences,
// and randomized traffic against a rule-level reference model.
module tb_dmem_arbiter;

   localparam int MAX = 8;
`ifdef DMEM_ARB_RR_EN
   localparam logic RR = 1'b1;
`else
   localparam logic RR = 1'b0;
`endif
   localparam logic T = 1'b1;
   localparam logic F = 1'b0;
   localparam logic [31:0] D = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we, ld_req, ld_we, ld_lock;
   logic [31:0] cpu_a, cpu_wd, ld_a, ld_wd;
   logic [31:0] cpu_rd, ld_rdata, mem_a, mem_wd, mem_rd;
   logic        cpu_stall, ld_gnt, ld_rvalid, mem_we;

   logic [31:0] mem     [256];
   logic [31:0] ref_mem [256];

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   bit          g_cpu, g_ld, m_force, m_in_burst, m_last_cpu, e_rvalid;
   int          m_burst;
   logic [31:0] e_rdata;

   always #5 clk = ~clk;

   assign mem_rd = mem[mem_a[9:2]];

   dmem_arbiter #(
      .DATA_WIDTH    (32),
      .ADDRESS_WIDTH (32),
      .MAX_BURST     (MAX)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_a     (cpu_a),
      .cpu_wd    (cpu_wd),
      .cpu_rd    (cpu_rd),
      .cpu_stall (cpu_stall),
      .ld_req    (ld_req),
      .ld_we     (ld_we),
      .ld_lock   (ld_lock),
      .ld_a      (ld_a),
      .ld_wd     (ld_wd),
      .ld_gnt    (ld_gnt),
      .ld_rvalid (ld_rvalid),
      .ld_rdata  (ld_rdata),
      .mem_we    (mem_we),
      .mem_a     (mem_a),
      .mem_wd    (mem_wd),
      .mem_rd    (mem_rd)
   );

   typedef struct {
      logic        cr, cw;
      logic [31:0] ca, cwd;
      logic        lr, lw, ll;
      logic [31:0] la, lwd;
      logic        e_gnt, e_stall;
      logic [31:0] e_crd;
      logic        e_rv;
      logic [31:0] e_rd;
   } vec_t;

   vec_t tbl [11];

   function automatic vec_t mk(input logic cr, cw, input logic [31:0] ca, cwd,
                               input logic lr, lw, ll, input logic [31:0] la, lwd,
                               input logic eg, es, input logic [31:0] ecrd,
                               input logic erv, input logic [31:0] erd);
      vec_t v;
      v.cr = cr; v.cw = cw; v.ca = ca; v.cwd = cwd;
      v.lr = lr; v.lw = lw; v.ll = ll; v.la = la; v.lwd = lwd;
      v.e_gnt = eg; v.e_stall = es; v.e_crd = ecrd; v.e_rv = erv; v.e_rd = erd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_force = 0; m_in_burst = 0; m_burst = 0; m_last_cpu = 0;
      e_rvalid = 0; e_rdata = '0; g_cpu = 0; g_ld = 0;
   endtask

   // Drive one cycle's inputs and check every output against the model.
   task automatic apply(input logic creq, cwe, input logic [31:0] ca, cwd,
                        input logic lreq, lwe, llock, input logic [31:0] la, lwd);
      cpu_req = creq; cpu_we = cwe; cpu_a = ca; cpu_wd = cwd;
      ld_req = lreq; ld_we = lwe; ld_lock = llock; ld_a = la; ld_wd = lwd;
      #1;
      if (m_force) begin
         g_cpu = creq; g_ld = 0;
      end else if (m_in_burst && lreq && llock) begin
         g_cpu = 0; g_ld = 1;
      end else if (creq && lreq) begin
         g_cpu = RR ? !m_last_cpu : 1'b1;
         g_ld  = !g_cpu;
      end else begin
         g_cpu = creq; g_ld = lreq;
      end
      chk("ld_gnt", ld_gnt, g_ld);
      chk("cpu_stall", cpu_stall, creq && !g_cpu);
      chk("cpu_rd", cpu_rd, g_cpu ? ref_mem[ca[9:2]] : 32'h0);
      chk("mem_we", mem_we, g_cpu ? cwe : (g_ld ? lwe : 1'b0));
      chk("mem_a", mem_a, g_cpu ? ca : (g_ld ? la : 32'h0));
      chk("mem_wd", mem_wd, g_cpu ? cwd : (g_ld ? lwd : 32'h0));
      chk("ld_rvalid", ld_rvalid, e_rvalid);
      chk("ld_rdata", ld_rdata, e_rdata);
   endtask

   // Advance the model by this cycle's outcome, then clock the DUT and memory.
   task automatic tick();
      logic        w;
      logic [31:0] wa, wd;
      if (g_ld && !ld_we) begin
         e_rvalid = 1; e_rdata = ref_mem[ld_a[9:2]];
      end else begin
         e_rvalid = 0;
      end
      if (g_cpu && cpu_we) ref_mem[cpu_a[9:2]] = cpu_wd;
      else if (g_ld && ld_we) ref_mem[ld_a[9:2]] = ld_wd;
      if (g_cpu) m_last_cpu = 1;
      else if (g_ld) m_last_cpu = 0;
      if (m_force) begin
         m_force = 0; m_in_burst = 0; m_burst = 0;
      end else if (g_ld && ld_lock) begin
         if (!m_in_burst) m_burst = 1;
         else if (cpu_req && m_burst < MAX) m_burst++;
         if (cpu_req && m_burst >= MAX) begin
            m_force = 1; m_in_burst = 0;
         end else begin
            m_in_burst = 1;
         end
      end else begin
         m_in_burst = 0; m_burst = 0;
      end
      w = mem_we; wa = mem_a; wd = mem_wd;
      @(posedge clk);
      if (w) mem[wa[9:2]] = wd;
      #1;
   endtask

   task automatic do_reset();
      rst = 1;
      cpu_req = 0; cpu_we = 0; cpu_a = '0; cpu_wd = '0;
      ld_req = 0; ld_we = 0; ld_lock = 0; ld_a = '0; ld_wd = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
   endtask

   initial begin
      logic        lr, lw, ll, el;
      logic [31:0] la, lwd;
      bit          creq;

      for (int i = 0; i < 256; i++) begin
         mem[i] = '0; ref_mem[i] = '0;
      end
      mem[4] = D; ref_mem[4] = D;

      tbl[0]  = mk(T, F, 32'h10, 32'h0, T, T, F, 32'h40, 32'h55, F, F, D, F, 32'h0);
      tbl[1]  = mk(T, F, 32'h10, 32'h0, T, T, F, 32'h40, 32'h55, RR, RR, RR ? 32'h0 : D, F, 32'h0);
      tbl[2]  = mk(T, F, 32'h10, 32'h0, T, T, F, 32'h40, 32'h55, F, F, D, F, 32'h0);
      tbl[3]  = mk(T, F, 32'h10, 32'h0, T, T, F, 32'h40, 32'h55, RR, RR, RR ? 32'h0 : D, F, 32'h0);
      tbl[4]  = mk(F, F, 32'h0, 32'h0, T, T, F, 32'h20, 32'h1234, T, F, 32'h0, F, 32'h0);
      tbl[5]  = mk(F, F, 32'h0, 32'h0, T, F, F, 32'h20, 32'h0, T, F, 32'h0, F, 32'h0);
      tbl[6]  = mk(F, F, 32'h0, 32'h0, F, F, F, 32'h0, 32'h0, F, F, 32'h0, T, 32'h1234);
      tbl[7]  = mk(T, F, 32'h20, 32'h0, F, F, F, 32'h0, 32'h0, F, F, 32'h1234, F, 32'h1234);
      tbl[8]  = mk(T, T, 32'h30, 32'hABCD, F, F, F, 32'h0, 32'h0, F, F, 32'h0, F, 32'h1234);
      tbl[9]  = mk(T, F, 32'h30, 32'h0, F, F, F, 32'h0, 32'h0, F, F, 32'hABCD, F, 32'h1234);
      tbl[10] = mk(F, F, 32'h0, 32'h0, F, F, F, 32'h0, 32'h0, F, F, 32'h0, F, 32'h1234);

      // reset state with no requests
      do_reset();
      apply(F, F, 32'h0, 32'h0, F, F, F, 32'h0, 32'h0);
      chk("idle_mem_we", mem_we, 1'b0);
      chk("idle_mem_a", mem_a, 32'h0);
      chk("idle_ld_gnt", ld_gnt, 1'b0);
      chk("idle_stall", cpu_stall, 1'b0);
      chk("rst_rvalid0", ld_rvalid, 1'b0);
      chk("rst_rdata0", ld_rdata, 32'h0);
      tick();

      do_reset();
      foreach (tbl[i]) begin
         apply(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cwd,
               tbl[i].lr, tbl[i].lw, tbl[i].ll, tbl[i].la, tbl[i].lwd);
         chk($sformatf("tbl%0d_ld_gnt", i), ld_gnt, tbl[i].e_gnt);
         chk($sformatf("tbl%0d_stall", i), cpu_stall, tbl[i].e_stall);
         chk($sformatf("tbl%0d_cpu_rd", i), cpu_rd, tbl[i].e_crd);
         chk($sformatf("tbl%0d_rvalid", i), ld_rvalid, tbl[i].e_rv);
         chk($sformatf("tbl%0d_rdata", i), ld_rdata, tbl[i].e_rd);
         tick();
      end

      // locked burst entered with the CPU idle, then CPU waits until forced in
      do_reset();
      for (int i = 0; i < 10; i++) begin
         creq = (i != 0);
         apply(creq, F, 32'h10, 32'h0, T, T, T, 32'h60, 32'h66);
         el = (i <= 7) || (i == 9 && RR);
         chk($sformatf("burstA%0d_ld_gnt", i), ld_gnt, el);
         chk($sformatf("burstA%0d_stall", i), cpu_stall, creq && el);
         tick();
      end

      // both requesting from reset with lock held
      do_reset();
      for (int i = 0; i < 11; i++) begin
         apply(T, F, 32'h10, 32'h0, T, T, T, 32'h70, 32'h77);
         el = RR && ((i >= 1 && i <= 8) || i == 10);
         chk($sformatf("burstB%0d_ld_gnt", i), ld_gnt, el);
         chk($sformatf("burstB%0d_stall", i), cpu_stall, el);
         tick();
      end

      // reset in the middle of a locked read burst
      do_reset();
      apply(F, F, 32'h0, 32'h0, T, F, T, 32'h10, 32'h0);
      tick();
      apply(F, F, 32'h0, 32'h0, T, F, T, 32'h10, 32'h0);
      tick();
      rst = 1;
      #1;
      model_reset();
      chk("midrst_rvalid", ld_rvalid, 1'b0);
      chk("midrst_rdata", ld_rdata, 32'h0);
      rst = 0;
      apply(T, F, 32'h10, 32'h0, T, F, T, 32'h10, 32'h0);
      chk("midrst_ld_gnt", ld_gnt, 1'b0);
      chk("midrst_cpu_rd", cpu_rd, D);
      tick();

      // randomized traffic; loader holds its request until granted or dropped
      do_reset();
      lr = 0; lw = 0; ll = 0; la = '0; lwd = '0;
      for (int i = 0; i < 800; i++) begin
         if (!lr || g_ld) begin
            lr  = ($urandom % 10) < 6;
            lw  = $urandom % 2;
            ll  = $urandom % 2;
            la  = {22'h0, 8'($urandom), 2'b00};
            lwd = $urandom;
         end else if ($urandom % 10 == 0) begin
            lr = 0;
         end
         apply(($urandom % 10) < 7, ($urandom % 10) < 3, {22'h0, 8'($urandom), 2'b00},
               $urandom, lr, lw, ll, la, lwd);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single data memory between the CPU load/store path and an external loader port (program/data preload, debug dump). It sits between the CPU's ALU-result/rd2 datapath and the data memory, drives the memory's address, write-data and write-enable, and returns read data. It also raises a stall request so the PC holds while the CPU is denied access.

## Interface
- `DATA_WIDTH`, 32, memory word width
- `ADDRESS_WIDTH`, 32, byte address width
- `MAX_BURST`, 8, max consecutive locked loader grants while CPU waits (≥1)
- `clk  input  1  clock; all state updates on rising edge`
- `rst  input  1  asynchronous, active-high reset`
- `cpu_req  input  1  CPU memory access this cycle (load or store)`
- `cpu_we  input  1  CPU store`
- `cpu_a  input  ADDRESS_WIDTH  CPU address`
- `cpu_wd  input  DATA_WIDTH  CPU store data`
- `cpu_rd  output  DATA_WIDTH  CPU load data, combinational from memory when granted, else 0`
- `cpu_stall  output  1  cpu_req & ~cpu_gnt; holds PC and suppresses regwrite`
- `ld_req  input  1  loader access request`
- `ld_we  input  1  loader write`
- `ld_lock  input  1  loader requests back-to-back ownership`
- `ld_a  input  ADDRESS_WIDTH  loader address`
- `ld_wd  input  DATA_WIDTH  loader write data`
- `ld_gnt  output  1  loader access performed this cycle`
- `ld_rvalid  output  1  registered: loader read data valid`
- `ld_rdata  output  DATA_WIDTH  registered loader read data`
- `mem_we  output  1  memory write enable`
- `mem_a  output  ADDRESS_WIDTH  memory address`
- `mem_wd  output  DATA_WIDTH  memory write data`
- `mem_rd  input  DATA_WIDTH  memory combinational read data`

## Operation
- Grant decision is combinational per cycle; at most one of cpu_gnt (internal), ld_gnt is 1.
- mem_a/mem_wd/mem_we muxed from the granted requester; no grant → mem_we=0, mem_a=0, mem_wd=0.
- States: ARB, LOCKED, FORCE_CPU.
- ARB: only one requester → grant it. Both → winner per Configuration. Loader granted with ld_lock=1 → next state LOCKED, burst count=1.
- LOCKED: ld_req=1 → loader granted unconditionally; count increments only while cpu_req=1. ld_lock=0 or ld_req=0 → ARB (decision that cycle uses ARB rules). Count reaches MAX_BURST with cpu_req=1 → FORCE_CPU.
- FORCE_CPU: CPU granted if cpu_req; loader denied regardless; always returns to ARB next cycle, count cleared.
- Loader read (ld_gnt & ~ld_we): mem_rd captured into ld_rdata, ld_rvalid=1 next cycle; otherwise ld_rvalid=0, ld_rdata holds.
- Loader must hold req/we/a/wd stable until ld_gnt; dropping req before grant is legal, no side effect.

## Timing
- Reset values: state=ARB, count=0, last-winner=loader (so CPU wins first tie), ld_rvalid=0, ld_rdata=0; all combinational outputs follow from these.
- CPU: zero-latency access when granted; cpu_stall asserted same cycle as denial.
- Loader: write completes at the ld_gnt edge; read data at +1 cycle.
- Reset asserted mid-burst: immediate return to ARB, pending ld_rvalid cleared.
- cpu_req and ld_req rising together after reset → CPU granted.
- count width $clog2(MAX_BURST+1); saturates, never wraps.

## Configuration
- `DMEM_ARB_RR_EN` defined: ARB tie resolved round-robin — winner is the requester not granted most recently (last-winner register updated on every grant).
- Undefined: fixed priority, CPU always wins ties in ARB; last-winner register not built. LOCKED/FORCE_CPU unchanged in both builds.

## Structure
- Shared package `dmem_arb_pkg`: state enum (ARB, LOCKED, FORCE_CPU), requester-ID enum (REQ_CPU, REQ_LD).
- One sub-module: `arb_burst_counter` (saturating count, clear, limit-reached flag).
- Top of cpu instantiates dmem_arbiter between datapath and data_mem; cpu_stall gates PC update and regwrite.

## Test plan
- Reset then cpu_req=1 load at 0x10, mem holds 0xDEADBEEF, no ld_req → cpu_rd=0xDEADBEEF same cycle, cpu_stall=0.
- cpu_req and ld_req both 1 for 4 cycles, ld_lock=0 → RR build: grants CPU,LD,CPU,LD; fixed build: CPU×4, ld_gnt=0, cpu_stall=0.
- Loader write 0x1234 to 0x20, then loader read 0x20 → ld_rvalid=1 one cycle after read grant, ld_rdata=0x1234.
- ld_lock=1, ld_req=1, cpu_req=1 continuously, MAX_BURST=8 → 8 loader grants with cpu_stall=1, then one CPU grant (FORCE_CPU), then ARB resumes.
- rst asserted during LOCKED with pending read → next cycle state ARB, ld_rvalid=0, ld_rdata=0.
- No requests → mem_we=0, mem_a=0, ld_gnt=0, cpu_stall=0.
